// File: rtl/snn_wb_master_if.sv
// Bundle of the burst-command, write/read stream and Wishbone initiator
// signals of snn_wb_master. The master modport is the initiator side, the
// slave modport is the SNN controller plus the WB bus it talks to.
//
// Handshake rule for cmd, wr and rd streams: a word moves on a rising clock
// edge where valid and ready are both high; the producer keeps valid and its
// payload steady until that edge, and the consumer may drive ready
// independently of valid.
interface snn_wb_master_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_we;
  logic [31:0]      cmd_adr;
  logic [LEN_W-1:0] cmd_len;
  logic             wr_valid;
  logic             wr_ready;
  logic [31:0]      wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [31:0]      rd_data;
  logic             done;
  logic             err;
  logic             wbm_cyc_o;
  logic             wbm_stb_o;
  logic             wbm_we_o;
  logic [3:0]       wbm_sel_o;
  logic [31:0]      wbm_adr_o;
  logic [31:0]      wbm_dat_o;
  logic [31:0]      wbm_dat_i;
  logic             wbm_ack_i;
  logic             wbm_err_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_len,
    output cmd_ready,
    input  wr_valid, wr_data,
    output wr_ready,
    output rd_valid, rd_data,
    input  rd_ready,
    output done, err,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i, wbm_err_i
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_len,
    input  cmd_ready,
    output wr_valid, wr_data,
    input  wr_ready,
    input  rd_valid, rd_data,
    output rd_ready,
    input  done, err,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i, wbm_err_i
  );
endinterface

// File: rtl/snn_wb_master.sv
// Wishbone classic initiator for the SNN user area. Runs a burst of
// cmd_len+1 single-beat WB cycles with CYC held across the burst, pulling
// write words from the wr stream and pushing read words onto the rd stream.
// Error or a stalled beat ends the burst early with err set alongside done.
module snn_wb_master #(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_ni,
  snn_wb_master_if.master       bus,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WDATA = 3'd1,
    S_REQ   = 3'd2,
    S_RDATA = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  // Last REQ cycle index before the beat is declared dead.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t           state_q;
  state_t           state_d;
  logic             we_q;
  logic             err_q;
  logic [31:0]      adr_q;
  logic [31:0]      dat_q;
  logic [31:0]      rd_data_q;
  logic [LEN_W-1:0] beats_q;
  logic [7:0]       tmo_q;
  logic             last_beat;
  logic             tmo_hit;

  assign last_beat = (beats_q == '0);
  assign tmo_hit   = (tmo_q == TMO_LAST);
  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state and state-decoded outputs; error beats ack, ack beats timeout.
  always_comb begin
    state_d       = state_q;
    bus.cmd_ready = 1'b0;
    bus.wr_ready  = 1'b0;
    bus.rd_valid  = 1'b0;
    bus.done      = 1'b0;
    bus.err       = 1'b0;
    bus.wbm_cyc_o = 1'b0;
    bus.wbm_stb_o = 1'b0;
    bus.wbm_we_o  = 1'b0;
    bus.wbm_sel_o = 4'b0000;
    case (state_q)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) state_d = bus.cmd_we ? S_WDATA : S_REQ;
      end
      S_WDATA: begin
        bus.wbm_cyc_o = 1'b1;
        bus.wr_ready  = 1'b1;
        if (bus.wr_valid) state_d = S_REQ;
      end
      S_REQ: begin
        bus.wbm_cyc_o = 1'b1;
        bus.wbm_stb_o = 1'b1;
        bus.wbm_we_o  = we_q;
        bus.wbm_sel_o = 4'b1111;
        if (bus.wbm_err_i) begin
          state_d = S_FIN;
        end else if (bus.wbm_ack_i) begin
          if (we_q) state_d = last_beat ? S_FIN : S_WDATA;
          else      state_d = S_RDATA;
        end else if (tmo_hit) begin
          state_d = S_FIN;
        end
      end
      S_RDATA: begin
        bus.wbm_cyc_o = 1'b1;
        bus.rd_valid  = 1'b1;
        if (bus.rd_ready) state_d = last_beat ? S_FIN : S_REQ;
      end
      S_FIN: begin
        bus.done = 1'b1;
        bus.err  = err_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;
  assign bus.rd_data   = rd_data_q;

  // Burst datapath: address/beat bookkeeping, data capture, stall counter.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      rd_data_q <= '0;
      beats_q   <= '0;
      tmo_q     <= '0;
    end else begin
      // The stall counter only runs inside REQ, so every entry starts at 0.
      tmo_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            we_q    <= bus.cmd_we;
            err_q   <= 1'b0;
            adr_q   <= {bus.cmd_adr[31:2], 2'b00};
            beats_q <= bus.cmd_len;
          end
        end
        S_WDATA: begin
          if (bus.wr_valid) dat_q <= bus.wr_data;
        end
        S_REQ: begin
          if (bus.wbm_err_i) begin
            err_q <= 1'b1;
          end else if (bus.wbm_ack_i) begin
            if (!we_q) begin
              rd_data_q <= bus.wbm_dat_i;
            end else if (!last_beat) begin
              beats_q <= beats_q - 1'b1;
              adr_q   <= adr_q + 32'd4;
            end
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        S_RDATA: begin
          if (bus.rd_ready && !last_beat) begin
            beats_q <= beats_q - 1'b1;
            adr_q   <= adr_q + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_wb_master.sv
// Bench for snn_wb_master: randomized command/stream/slave stimulus checked
// every cycle against a transaction-level model of the burst protocol.
module tb_snn_wb_master;
  localparam int LEN_W   = 8;
  localparam int TIMEOUT = 255;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  snn_wb_master_if #(.LEN_W(LEN_W)) bus ();
  logic [2:0] dbg_state;

  snn_wb_master #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- counters ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus controls ----------------
  bit               cmd_pending;
  bit               c_we;
  logic [31:0]      c_adr;
  logic [LEN_W-1:0] c_len;
  bit               spur;
  int sl_wait_lo, sl_wait_hi, sl_err_idx, sl_silent_idx;
  bit sl_err_ack;
  int wr_lo, wr_hi, rd_lo, rd_hi;
  int rd_delay_q[$];

  // driver-private state
  bit sl_in_req;
  int sl_cnt, sl_wait, sl_idx;
  int wr_cnt, wr_delay, rd_cnt, rd_delay;

  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], ~a[31:16]};
  endfunction

  // ---------------- model / scoreboard ----------------
  logic [31:0] exp_q[$];        // read words the DUT must present, in order
  bit          m_busy, m_fin, m_stb, m_wrr, m_rdv, m_we, m_err;
  logic [31:0] m_adr, m_dat;
  int          m_left, m_wcnt;
  bit          fin_seen;

  // observation logs for hand-computed pins
  logic [31:0] adr_log[$];
  logic [31:0] rd_log[$];
  int done_cnt, wr_ack_cnt, rdv_cycles, cur_stb_len, last_stb_len;
  bit last_err, prev_stb;

  task automatic model_reset();
    m_busy = 0; m_fin = 0; m_stb = 0; m_wrr = 0; m_rdv = 0; m_we = 0; m_err = 0;
    m_adr = '0; m_dat = '0; m_left = 0; m_wcnt = 0;
    exp_q.delete();
    prev_stb = 0;
    cmd_pending = 0;
  endtask

  // ---------------- drivers ----------------
  task automatic drive();
    // command
    if (cmd_pending) begin
      bus.cmd_valid = 1'b1; bus.cmd_we = c_we; bus.cmd_adr = c_adr; bus.cmd_len = c_len;
    end else begin
      bus.cmd_valid = 1'b0; bus.cmd_we = 1'($urandom_range(0, 1));
      bus.cmd_adr = $urandom; bus.cmd_len = LEN_W'($urandom);
    end
    // WB slave
    bus.wbm_ack_i = 1'b0; bus.wbm_err_i = 1'b0; bus.wbm_dat_i = $urandom;
    if (bus.wbm_stb_o) begin
      if (!sl_in_req) begin
        sl_in_req = 1; sl_cnt = 0; sl_wait = $urandom_range(sl_wait_hi, sl_wait_lo);
      end
      if (sl_cnt == sl_wait) begin
        if (sl_idx == sl_silent_idx) begin
          bus.wbm_ack_i = 1'b0;
        end else if (sl_idx == sl_err_idx) begin
          bus.wbm_err_i = 1'b1; bus.wbm_ack_i = sl_err_ack;
        end else begin
          bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = mem_rd(bus.wbm_adr_o);
        end
      end
      sl_cnt++;
    end else begin
      if (sl_in_req) sl_idx++;
      sl_in_req = 0;
      if (spur) begin
        bus.wbm_ack_i = ($urandom_range(0, 3) == 0);
        bus.wbm_err_i = ($urandom_range(0, 5) == 0);
      end
    end
    // write stream producer
    if (bus.wr_ready) begin
      if (wr_cnt < wr_delay) begin
        bus.wr_valid = 1'b0; wr_cnt++;
      end else begin
        bus.wr_valid = 1'b1; bus.wr_data = $urandom; wr_cnt = 0;
        wr_delay = $urandom_range(wr_hi, wr_lo);
      end
    end else begin
      wr_cnt = 0;
      bus.wr_valid = spur && ($urandom_range(0, 1) == 1);
      bus.wr_data = $urandom;
    end
    // read stream consumer
    if (bus.rd_valid) begin
      if (rd_cnt < rd_delay) begin
        bus.rd_ready = 1'b0; rd_cnt++;
      end else begin
        bus.rd_ready = 1'b1; rd_cnt = 0;
        rd_delay = (rd_delay_q.size() > 0) ? rd_delay_q.pop_front() : $urandom_range(rd_hi, rd_lo);
      end
    end else begin
      rd_cnt = 0;
      bus.rd_ready = spur && ($urandom_range(0, 1) == 1);
    end
  endtask

  // ---------------- per-cycle compare + model step ----------------
  task automatic compare_and_model();
    if (!rst_n) begin
      check("rst_cmd_ready", bus.cmd_ready, 1);
      check("rst_cyc", bus.wbm_cyc_o, 0);
      check("rst_stb", bus.wbm_stb_o, 0);
      check("rst_done", bus.done, 0);
      check("rst_rd_valid", bus.rd_valid, 0);
      check("rst_wr_ready", bus.wr_ready, 0);
      check("rst_rd_data", bus.rd_data, 0);
      check("rst_adr", bus.wbm_adr_o, 0);
      model_reset();
      return;
    end
    check("cmd_ready", bus.cmd_ready, !m_busy);
    check("cyc", bus.wbm_cyc_o, m_busy && !m_fin);
    check("stb", bus.wbm_stb_o, m_stb);
    check("sel", bus.wbm_sel_o, m_stb ? 4'hF : 4'h0);
    check("wr_ready", bus.wr_ready, m_wrr);
    check("rd_valid", bus.rd_valid, m_rdv);
    check("done", bus.done, m_fin);
    if (m_stb) begin
      check("adr", bus.wbm_adr_o, m_adr);
      check("we", bus.wbm_we_o, m_we);
      if (m_we) check("dat_o", bus.wbm_dat_o, m_dat);
    end
    if (m_rdv && exp_q.size() > 0) check("rd_data", bus.rd_data, exp_q[0]);
    if (m_fin) check("err", bus.err, m_err);

    // observation logs
    if (bus.wbm_stb_o && !prev_stb) begin adr_log.push_back(bus.wbm_adr_o); cur_stb_len = 0; end
    if (bus.wbm_stb_o) cur_stb_len++;
    else if (prev_stb) last_stb_len = cur_stb_len;
    prev_stb = bus.wbm_stb_o;
    if (bus.rd_valid) rdv_cycles++;
    if (bus.rd_valid && bus.rd_ready) rd_log.push_back(bus.rd_data);
    if (bus.done) begin done_cnt++; last_err = bus.err; end
    if (bus.wbm_stb_o && bus.wbm_we_o && bus.wbm_ack_i && !bus.wbm_err_i) wr_ack_cnt++;

    // model step: what this cycle's inputs imply for the next cycle
    if (m_fin) begin
      m_fin = 0; m_busy = 0; fin_seen = 1;
    end else if (!m_busy) begin
      if (bus.cmd_valid) begin
        m_busy = 1; m_we = bus.cmd_we; m_adr = {bus.cmd_adr[31:2], 2'b00};
        m_left = int'(bus.cmd_len) + 1; m_err = 0;
        if (m_we) m_wrr = 1;
        else begin m_stb = 1; m_wcnt = 0; end
        cmd_pending = 0;
      end
    end else if (m_wrr) begin
      if (bus.wr_valid) begin m_dat = bus.wr_data; m_wrr = 0; m_stb = 1; m_wcnt = 0; end
    end else if (m_stb) begin
      m_wcnt++;
      if (bus.wbm_err_i) begin
        m_stb = 0; m_err = 1; m_fin = 1;
      end else if (bus.wbm_ack_i) begin
        m_stb = 0;
        if (m_we) begin
          if (m_left == 1) m_fin = 1;
          else begin m_left--; m_adr = m_adr + 32'd4; m_wrr = 1; end
        end else begin
          exp_q.push_back(bus.wbm_dat_i); m_rdv = 1;
        end
      end else if (m_wcnt == TIMEOUT) begin
        m_stb = 0; m_err = 1; m_fin = 1;
      end
    end else if (m_rdv) begin
      if (bus.rd_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        m_rdv = 0;
        if (m_left == 1) m_fin = 1;
        else begin m_left--; m_adr = m_adr + 32'd4; m_stb = 1; m_wcnt = 0; end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    drive();
    #1;
    compare_and_model();
  endtask

  task automatic start_burst(input bit we, input logic [31:0] adr, input logic [LEN_W-1:0] len);
    c_we = we; c_adr = adr; c_len = len; cmd_pending = 1; fin_seen = 0;
    sl_idx = 0; sl_in_req = 0;
    adr_log.delete(); rd_log.delete();
    done_cnt = 0; wr_ack_cnt = 0; rdv_cycles = 0; last_stb_len = 0; last_err = 0;
    wr_cnt = 0; rd_cnt = 0;
    wr_delay = $urandom_range(wr_hi, wr_lo);
    rd_delay = (rd_delay_q.size() > 0) ? rd_delay_q.pop_front() : $urandom_range(rd_hi, rd_lo);
  endtask

  task automatic run_burst(input bit we, input logic [31:0] adr, input logic [LEN_W-1:0] len);
    int n;
    start_burst(we, adr, len);
    n = 0;
    while (!fin_seen && n < 4000) begin cycle(); n++; end
    check("burst_finished_in_budget", fin_seen, 1);
    cycle();
  endtask

  task automatic quiet_slave();
    sl_wait_lo = 0; sl_wait_hi = 0; sl_err_idx = -1; sl_silent_idx = -1; sl_err_ack = 0;
    wr_lo = 0; wr_hi = 0; rd_lo = 0; rd_hi = 0; rd_delay_q.delete(); spur = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n, len_r;
    bus.cmd_valid = 0; bus.cmd_we = 0; bus.cmd_adr = '0; bus.cmd_len = '0;
    bus.wr_valid = 0; bus.wr_data = '0; bus.rd_ready = 0;
    bus.wbm_dat_i = '0; bus.wbm_ack_i = 0; bus.wbm_err_i = 0;
    quiet_slave();
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) cycle();
    rst_n = 1'b1;
    repeat (2) cycle();

    // read burst, zero wait states
    mem[32'h3000_0000] = 32'hA0; mem[32'h3000_0004] = 32'hA1; mem[32'h3000_0008] = 32'hA2;
    run_burst(0, 32'h3000_0001, 8'd2);
    check("rd_adr_count", adr_log.size(), 3);
    if (adr_log.size() == 3) begin
      check("rd_adr0", adr_log[0], 32'h3000_0000);
      check("rd_adr1", adr_log[1], 32'h3000_0004);
      check("rd_adr2", adr_log[2], 32'h3000_0008);
    end
    check("rd_word_count", rd_log.size(), 3);
    if (rd_log.size() == 3) begin
      check("rd_word0", rd_log[0], 32'hA0);
      check("rd_word1", rd_log[1], 32'hA1);
      check("rd_word2", rd_log[2], 32'hA2);
    end
    check("rd_done_once", done_cnt, 1);
    check("rd_err", last_err, 0);

    // write burst with producer stalls and two slave wait states
    wr_lo = 3; wr_hi = 3; sl_wait_lo = 2; sl_wait_hi = 2;
    run_burst(1, 32'h1000_0010, 8'd1);
    check("wr_acks", wr_ack_cnt, 2);
    check("wr_stb_len", last_stb_len, 3);
    check("wr_done_once", done_cnt, 1);
    check("wr_err", last_err, 0);
    if (adr_log.size() == 2) check("wr_adr1", adr_log[1], 32'h1000_0014);
    else check("wr_adr_count", adr_log.size(), 2);

    // read backpressure: consumer holds off word 0 for five cycles
    quiet_slave();
    rd_delay_q.push_back(5);
    run_burst(0, 32'h2000_0000, 8'd1);
    check("bp_rdv_cycles", rdv_cycles, 7);
    check("bp_words", rd_log.size(), 2);
    check("bp_reqs", adr_log.size(), 2);

    // bus error with ack on beat 1 of a four-beat read
    quiet_slave();
    sl_err_idx = 1; sl_err_ack = 1;
    run_burst(0, 32'h4000_0000, 8'd3);
    check("berr_reqs", adr_log.size(), 2);
    check("berr_words", rd_log.size(), 1);
    check("berr_done_once", done_cnt, 1);
    check("berr_err", last_err, 1);

    // timeout on a single-beat write
    quiet_slave();
    sl_silent_idx = 0;
    run_burst(1, 32'h5000_0000, 8'd0);
    check("tmo_stb_len", last_stb_len, TIMEOUT);
    check("tmo_err", last_err, 1);

    // address wrap
    quiet_slave();
    run_burst(0, 32'hFFFF_FFFC, 8'd1);
    check("wrap_adr_count", adr_log.size(), 2);
    if (adr_log.size() == 2) begin
      check("wrap_adr0", adr_log[0], 32'hFFFF_FFFC);
      check("wrap_adr1", adr_log[1], 32'h0000_0000);
    end

    // asynchronous reset while a beat is stalled in the request phase
    quiet_slave();
    sl_silent_idx = 0;
    start_burst(0, 32'h6000_0000, 8'd4);
    n = 0;
    while (!bus.wbm_stb_o && n < 20) begin cycle(); n++; end
    check("rst_reached_req", bus.wbm_stb_o, 1);
    repeat (3) cycle();
    #2 rst_n = 1'b0;
    #1;
    check("async_cyc", bus.wbm_cyc_o, 0);
    check("async_stb", bus.wbm_stb_o, 0);
    check("async_done", bus.done, 0);
    check("async_cmd_ready", bus.cmd_ready, 1);
    done_cnt = 0;
    repeat (3) cycle();
    rst_n = 1'b1;
    sl_silent_idx = -1;
    repeat (4) cycle();
    check("async_no_done", done_cnt, 0);

    // randomized bursts with spurious bus/stream activity
    for (int t = 0; t < 30; t++) begin
      spur = 1;
      sl_wait_lo = 0; sl_wait_hi = 3;
      wr_lo = 0; wr_hi = 3; rd_lo = 0; rd_hi = 3;
      rd_delay_q.delete();
      len_r = $urandom_range(0, 7);
      sl_err_idx = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len_r) : -1;
      sl_err_ack = 1'($urandom_range(0, 1));
      sl_silent_idx = ($urandom_range(0, 11) == 0) ? $urandom_range(0, len_r) : -1;
      run_burst(1'($urandom_range(0, 1)), $urandom, LEN_W'(len_r));
      check("rand_done_once", done_cnt, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snn_wb_master.md
Name: snn_wb_master

Overview:
- Wishbone classic initiator (master) for the SNN user area; the initiator end of the same WB bus the SNN slave responds on.
- Accepts a burst command (address, length, direction) from the SNN controller, issues one WB single-beat cycle per word with CYC held for the whole burst, and streams write data in and read data out over valid/ready handshakes.
- Used to fetch weights/membrane state from, and write spikes back to, WB-mapped memory.

Parameters:
- LEN_W, 8, width of cmd_len; burst length = cmd_len+1 words (1..2^LEN_W).
- TIMEOUT, 255, max cycles STB may wait for ACK/ERR before abort; 8-bit counter.

Ports:
- wb_clk_i  input  1  clock; all logic on rising edge.
- wb_rst_ni  input  1  asynchronous active-low reset.
- cmd_valid  input  1  burst command valid.
- cmd_ready  output  1  high only in IDLE.
- cmd_we  input  1  1 = write burst, 0 = read burst.
- cmd_adr  input  32  start byte address; bits [1:0] ignored.
- cmd_len  input  LEN_W  words minus one.
- wr_valid  input  1  write word available.
- wr_ready  output  1  write word consumed this cycle.
- wr_data  input  32  write word.
- rd_valid  output  1  read word held on rd_data.
- rd_ready  input  1  consumer accepts rd_data.
- rd_data  output  32  read word.
- done  output  1  one-cycle pulse at burst end.
- err  output  1  valid with done: 1 = bus error or timeout.
- wbm_cyc_o  output  1  WB cycle.
- wbm_stb_o  output  1  WB strobe.
- wbm_we_o  output  1  WB write enable.
- wbm_sel_o  output  4  byte selects; always 4'b1111 while stb, else 0.
- wbm_adr_o  output  32  word-aligned address, [1:0]=0.
- wbm_dat_o  output  32  write data.
- wbm_dat_i  input  32  read data.
- wbm_ack_i  input  1  WB acknowledge.
- wbm_err_i  input  1  WB error.

Behaviour:
- Reset (async, wb_rst_ni=0): state IDLE; all outputs 0 except cmd_ready=1; address/beat/timeout counters 0; rd_data 0.
- States: IDLE, WDATA, REQ, RDATA, FIN.
- IDLE: cmd_ready=1. On cmd_valid: latch we, adr&~3, beats=cmd_len; next = WDATA if we else REQ. wbm_cyc_o rises the cycle after acceptance and stays 1 until FIN.
- WDATA: wr_ready=1, stb=0. On wr_valid: wr_data -> wbm_dat_o, next REQ.
- REQ: stb=1, we=latched we, adr=current. Timeout counter increments each REQ cycle, cleared on entry.
  - wbm_err_i (wins over simultaneous ack) or counter reaching TIMEOUT -> FIN with err=1; remaining beats abandoned.
  - ack, write: if beats==0 -> FIN else beats-1, adr+4, -> WDATA.
  - ack, read: wbm_dat_i -> rd_data, rd_valid=1, -> RDATA.
- RDATA: stb=0, cyc=1, rd_valid=1 until rd_ready; on rd_ready: if beats==0 -> FIN else beats-1, adr+4, -> REQ.
- FIN: cyc=stb=0, done=1 for exactly one cycle, err as determined; next IDLE. Next command is accepted no earlier than the cycle after FIN.
- Address increments mod 2^32 (0xFFFFFFFC+4 -> 0x00000000), no error.
- Minimum per-word cost: write = 1 WDATA + REQ-until-ack; read = REQ-until-ack + 1 RDATA cycle.
- stb never asserted without cyc. wbm_adr_o/wbm_dat_o/wbm_we_o stable while stb=1.
- ack/err outside REQ are ignored.
- Reset mid-burst: immediate return to reset values; no done pulse.

Test Plan:
- Read burst: cmd adr=0x3000_0001, len=2, we=0; slave acks in 1 cycle with 0xA0, 0xA1, 0xA2; rd_ready=1 -> adr 0x30000000/04/08, rd_data sequence A0,A1,A2, cyc continuous, done=1 err=0 once.
- Write burst with stalls: len=1, wr_valid delayed 3 cycles per word, slave ack after 2 wait states -> stb only while data held, wbm_dat_o=wr_data per beat, two acks, done err=0.
- Read backpressure: rd_ready low 5 cycles on word 0 -> rd_valid/rd_data held, no new stb until accept.
- Bus error: err asserted with ack on beat 1 of len=3 -> FIN next cycle, done=1 err=1, beats 2-3 never issued, cyc low.
- Timeout: no ack for 255 REQ cycles -> done=1 err=1; cmd_ready=1 the following cycle.
- Wrap and reset: adr=0xFFFF_FFFC len=1 -> second address 0x0000_0000; assert wb_rst_ni=0 mid-REQ -> cyc/stb drop asynchronously, no done.
